imm_ext_pipe: RTL
=================

# imm_ext_pipe

Parametrised, pipelined immediate-extension unit that replaces the fixed 16→32 shifted-sign-extend path in the decode stage. It accepts an immediate, a mode and the current PC, and produces the extended immediate plus a PC-relative branch target. It sits between instruction decode and the execute/branch-resolution logic, behind a valid/ready handshake with a 2-entry output buffer, so decode can absorb one cycle of downstream stall without losing data.

## Interface

Parameters
- DATA_W, default 16: immediate field width.
- OUT_W, default 32: extended data and PC width.
- SHAMT, default 2: left shift applied in branch mode. Legal range: OUT_W ≥ DATA_W + SHAMT.
- PC_INC, default 4: constant added to the PC for the branch target.

Ports
- clk, input, 1: clock. All state changes on the rising edge.
- rst_n, input, 1: reset. Asynchronous, active-low.
- flush, input, 1: synchronous clear of all buffered entries.
- in_valid, input, 1: input entry present.
- in_ready, output, 1: the unit can accept an entry this cycle.
- in_mode, input, 2: extension mode. 00 zero, 01 sign, 10 branch, 11 upper.
- in_data, input, DATA_W: raw immediate.
- in_pc, input, OUT_W: PC of the instruction.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: consumer takes the head entry.
- out_ext, output, OUT_W: extended immediate of the head entry.
- out_target, output, OUT_W: in_pc + PC_INC + out_ext, mod 2^OUT_W, for the head entry.
- out_mode, output, 2: mode of the head entry, passed through.

## Operation

- Extension is computed combinationally from the inputs and stored at push.
  - Mode 00 (zero): upper OUT_W−DATA_W bits are 0.
  - Mode 01 (sign): the upper bits replicate in_data[DATA_W−1].
  - Mode 10 (branch): form in_data followed by SHAMT zeros, then sign-extend from bit DATA_W+SHAMT−1 to OUT_W.
  - Mode 11 (upper): in_data placed in the top DATA_W bits, lower bits 0.
- out_target is computed for every mode and stored at push. The consumer ignores it when it does not apply.
- Storage is a 2-entry FIFO: two slots, 1-bit read and write pointers, and a 2-bit count (0..2).
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != 2). It depends on state only and has no combinational path from out_ready.
- out_valid = (count != 0). The out_* signals are driven from the slot selected by the read pointer.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: count unchanged, both pointers advance.
- Entries leave in acceptance order. Pointers wrap modulo 2.
- flush:
  - Sets count and both pointers to 0.
  - Takes priority over any push or pop in the same cycle. A simultaneous push is dropped and a simultaneous pop is void.
- Reset (rst_n low, at any time, including mid-stall):
  - Count and pointers go to 0, so out_valid=0 and in_ready=1.
  - out_ext, out_target and out_mode read 0: the slot registers are also cleared.
  - Operation resumes on the first rising edge after rst_n returns high.
- out_* values are don't-care when out_valid=0, but must be stable while out_valid=1 && !out_ready.

## Timing

- Latency: an entry pushed at edge N is visible at out_* after edge N (out_valid high in cycle N+1) if the FIFO was empty.
- Throughput: 1 entry/cycle when out_ready is held high.
- Stall: with out_ready low, two pushes fill the FIFO. in_ready drops in the cycle after the second push.
- From full, one pop raises in_ready in the next cycle.
- Reset values: out_valid=0, in_ready=1, out_ext=0, out_target=0, out_mode=00.
- The target adder and extension logic must fit in one cycle at the decode-stage clock.

## Test plan

- Modes, DATA_W=16, OUT_W=32, out_ready=1:
  - zero, 0x8000 → out_ext 0x00008000.
  - sign, 0x8000 → out_ext 0xFFFF8000.
  - upper, 0x1234 → out_ext 0x12340000.
  - Each appears one cycle after push.
- Branch, negative offset: in_data 0xFFFF, in_pc 0x00400000 → out_ext 0xFFFFFFFC, out_target 0x00400000.
- Branch, positive offset: in_data 0x0003, in_pc 0x00400010 → out_ext 0x0000000C, out_target 0x00400020.
- Backpressure: out_ready=0, offer A, B, C back-to-back.
  - A and B are accepted and in_ready goes 0; C is held.
  - Raise out_ready: outputs appear in order A, B, C, with no loss or duplication.
  - out_* stay stable while stalled.
- Simultaneous push/pop at count=1 over 10 cycles: count stays 1, order is preserved, and pointers wrap correctly.
- flush with push and pop asserted in the same cycle at count=2: next cycle out_valid=0, in_ready=1, and the pushed entry never appears.
- rst_n pulsed low mid-cycle while full and stalled: outputs go to reset values immediately, without waiting for clk. After release, a new push behaves normally.

Source files
------------

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module  : imm_ext_pipe
// Brief   : Pipelined immediate extension + PC-relative target, 2-entry
//           output FIFO behind a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module imm_ext_pipe #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32,
    parameter int SHAMT  = 2,
    parameter int PC_INC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OUT_W-1:0]  in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_ext,
    output logic [OUT_W-1:0]  out_target,
    output logic [1:0]        out_mode
);

    localparam logic [1:0] c_MODE_ZERO   = 2'b00;
    localparam logic [1:0] c_MODE_SIGN   = 2'b01;
    localparam logic [1:0] c_MODE_BRANCH = 2'b10;
    localparam logic [1:0] c_MODE_UPPER  = 2'b11;
    localparam logic [1:0] c_FULL        = 2'd2;

    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] w_target;
    logic             w_push;
    logic             w_pop;

    logic [OUT_W-1:0] r_ext  [2];
    logic [OUT_W-1:0] r_tgt  [2];
    logic [1:0]       r_mode [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    assign w_zext = OUT_W'(in_data);
    assign w_sext = OUT_W'($signed(in_data));

    // Shifting the sign-extended value equals sign-extending from bit DATA_W+SHAMT-1.
    always_comb begin
        w_ext = w_zext;
        case (in_mode)
            c_MODE_ZERO:   w_ext = w_zext;
            c_MODE_SIGN:   w_ext = w_sext;
            c_MODE_BRANCH: w_ext = w_sext << SHAMT;
            c_MODE_UPPER:  w_ext = w_zext << (OUT_W - DATA_W);
            default:       w_ext = w_zext;
        endcase
    end

    assign w_target  = in_pc + OUT_W'(PC_INC) + w_ext;

    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_ext    = r_ext[r_rptr];
    assign out_target = r_tgt[r_rptr];
    assign out_mode   = r_mode[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext[0]  <= '0;
            r_ext[1]  <= '0;
            r_tgt[0]  <= '0;
            r_tgt[1]  <= '0;
            r_mode[0] <= '0;
            r_mode[1] <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
        end else if (flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_ext[r_wptr]  <= w_ext;
                r_tgt[r_wptr]  <= w_target;
                r_mode[r_wptr] <= in_mode;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
